// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit: decodes ALUOp/Function/Opcode into an ALU operation code
// and tracks HI/LO occupancy of in-flight MULT/DIV operations with a countdown counter.
module alu_ctrl_seq #(
  parameter int FUNC_SIZE   = 6,
  parameter int OP_SIZE     = 6,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter logic [FUNC_SIZE-1:0] F_ADD  = 'h20,
  parameter logic [FUNC_SIZE-1:0] F_SUB  = 'h22,
  parameter logic [FUNC_SIZE-1:0] F_AND  = 'h24,
  parameter logic [FUNC_SIZE-1:0] F_OR   = 'h25,
  parameter logic [FUNC_SIZE-1:0] F_NOR  = 'h27,
  parameter logic [FUNC_SIZE-1:0] F_SLT  = 'h2A,
  parameter logic [FUNC_SIZE-1:0] F_SLL  = 'h00,
  parameter logic [FUNC_SIZE-1:0] F_SRL  = 'h02,
  parameter logic [FUNC_SIZE-1:0] F_MULT = 'h18,
  parameter logic [FUNC_SIZE-1:0] F_DIV  = 'h1A,
  parameter logic [FUNC_SIZE-1:0] F_MFHI = 'h10,
  parameter logic [FUNC_SIZE-1:0] F_MFLO = 'h12,
  parameter logic [OP_SIZE-1:0] OP_BGEZ = 'h01,
  parameter logic [OP_SIZE-1:0] OP_BEQ  = 'h04,
  parameter logic [OP_SIZE-1:0] OP_ADDI = 'h08,
  parameter logic [OP_SIZE-1:0] OP_SLTI = 'h0A,
  parameter logic [OP_SIZE-1:0] OP_ANDI = 'h0C,
  parameter logic [OP_SIZE-1:0] OP_ORI  = 'h0D,
  parameter logic [OP_SIZE-1:0] OP_LUI  = 'h0F,
  parameter logic [OP_SIZE-1:0] ALU_AND  = 'h00,
  parameter logic [OP_SIZE-1:0] ALU_OR   = 'h01,
  parameter logic [OP_SIZE-1:0] ALU_ADD  = 'h02,
  parameter logic [OP_SIZE-1:0] ALU_SLL  = 'h03,
  parameter logic [OP_SIZE-1:0] ALU_SRL  = 'h04,
  parameter logic [OP_SIZE-1:0] ALU_MULT = 'h05,
  parameter logic [OP_SIZE-1:0] ALU_SUB  = 'h06,
  parameter logic [OP_SIZE-1:0] ALU_SLT  = 'h07,
  parameter logic [OP_SIZE-1:0] ALU_DIV  = 'h08,
  parameter logic [OP_SIZE-1:0] ALU_MFHI = 'h09,
  parameter logic [OP_SIZE-1:0] ALU_MFLO = 'h0A,
  parameter logic [OP_SIZE-1:0] ALU_LUI  = 'h0B,
  parameter logic [OP_SIZE-1:0] ALU_NOR  = 'h0C,
  parameter logic [OP_SIZE-1:0] ALU_BEQ  = 'h0D,
  parameter logic [OP_SIZE-1:0] ALU_BGEZ = 'h0E
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           ALUOp,
  input  logic [FUNC_SIZE-1:0] Function,
  input  logic [OP_SIZE-1:0]   Opcode,
  output logic                 stall,
  output logic [OP_SIZE-1:0]   Operation,
  output logic                 out_valid,
  output logic                 illegal,
  output logic                 hilo_busy,
  output logic                 md_done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  logic [OP_SIZE-1:0] dec_op;
  logic               legal;
  logic               is_rtype;
  logic               is_hilo;
  logic               is_mult;
  logic               is_div;
  logic               accept;
  logic [CW-1:0]      count;

  always_comb begin
    dec_op = '0;
    legal  = 1'b0;
    case (ALUOp)
      2'b00: begin dec_op = ALU_ADD; legal = 1'b1; end
      2'b01: begin
        if (Opcode == OP_BEQ)       begin dec_op = ALU_BEQ;  legal = 1'b1; end
        else if (Opcode == OP_BGEZ) begin dec_op = ALU_BGEZ; legal = 1'b1; end
      end
      2'b10: begin
        legal = 1'b1;
        case (Function)
          F_ADD:   dec_op = ALU_ADD;
          F_SUB:   dec_op = ALU_SUB;
          F_AND:   dec_op = ALU_AND;
          F_OR:    dec_op = ALU_OR;
          F_NOR:   dec_op = ALU_NOR;
          F_SLT:   dec_op = ALU_SLT;
          F_SLL:   dec_op = ALU_SLL;
          F_SRL:   dec_op = ALU_SRL;
          F_MULT:  dec_op = ALU_MULT;
          F_DIV:   dec_op = ALU_DIV;
          F_MFHI:  dec_op = ALU_MFHI;
          F_MFLO:  dec_op = ALU_MFLO;
          default: legal  = 1'b0;
        endcase
      end
      default: begin
        legal = 1'b1;
        case (Opcode)
          OP_ADDI: dec_op = ALU_ADD;
          OP_ORI:  dec_op = ALU_OR;
          OP_ANDI: dec_op = ALU_AND;
          OP_SLTI: dec_op = ALU_SLT;
          OP_LUI:  dec_op = ALU_LUI;
          default: legal  = 1'b0;
        endcase
      end
    endcase
  end

  // Handshake: a presented instruction (in_valid) is accepted unless it touches HI/LO
  // while a MULT/DIV is in flight; a stalled producer holds its fields stable.
  assign is_rtype = (ALUOp == 2'b10);
  assign is_mult  = is_rtype && (Function == F_MULT);
  assign is_div   = is_rtype && (Function == F_DIV);
  assign is_hilo  = is_mult || is_div ||
                    (is_rtype && ((Function == F_MFHI) || (Function == F_MFLO)));
  assign stall    = in_valid && hilo_busy && is_hilo;
  assign accept   = in_valid && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Operation <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      hilo_busy <= 1'b0;
      md_done   <= 1'b0;
      count     <= '0;
    end else begin
      out_valid <= accept;
      illegal   <= accept && !legal;
      md_done   <= 1'b0;
      if (accept && legal) Operation <= dec_op;
      // MULT/DIV can only be accepted while idle, so arming never collides with countdown.
      if (accept && (is_mult || is_div)) begin
        count     <= is_mult ? MULT_LOAD : DIV_LOAD;
        hilo_busy <= 1'b1;
      end else if (hilo_busy) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          hilo_busy <= 1'b0;
          md_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode results go through an expected queue,
// HI/LO busy/stall/done timing is checked cycle by cycle.
module tb_alu_ctrl_seq;

  localparam int OPW = 6;

  localparam logic [5:0] A_AND = 6'h00, A_OR = 6'h01, A_ADD = 6'h02, A_MULT = 6'h05,
                         A_SUB = 6'h06, A_SLT = 6'h07, A_DIV = 6'h08, A_MFHI = 6'h09,
                         A_MFLO = 6'h0A, A_LUI = 6'h0B, A_NOR = 6'h0C, A_BEQ = 6'h0D,
                         A_BGEZ = 6'h0E;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [1:0]     alu_op;
  logic [5:0]     funct;
  logic [5:0]     opcode;
  logic           stall;
  logic [OPW-1:0] operation;
  logic           out_valid;
  logic           illegal;
  logic           hilo_busy;
  logic           md_done;

  logic [OPW:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int md_done_seen = 0;

  alu_ctrl_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ALUOp     (alu_op),
    .Function  (funct),
    .Opcode    (opcode),
    .stall     (stall),
    .Operation (operation),
    .out_valid (out_valid),
    .illegal   (illegal),
    .hilo_busy (hilo_busy),
    .md_done   (md_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every out_valid pulse pops one expected {illegal, Operation}
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          logic [OPW:0] e;
          e = exp_q.pop_front();
          check("sb_illegal", 32'(illegal), 32'(e[OPW]));
          check("sb_operation", 32'(operation), 32'(e[OPW-1:0]));
        end
      end else begin
        check("illegal_without_valid", 32'(illegal), 32'd0);
      end
      if (md_done) md_done_seen++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic drive(input logic [1:0] a, input logic [5:0] f, input logic [5:0] o);
    in_valid = 1'b1;
    alu_op   = a;
    funct    = f;
    opcode   = o;
  endtask

  // one-cycle issue that must be accepted; pushes the expected result
  task automatic issue(input logic [1:0] a, input logic [5:0] f, input logic [5:0] o,
                       input logic ill, input logic [5:0] op);
    drive(a, f, o);
    exp_q.push_back({ill, op});
    @(negedge clk);
    check("issue_no_stall", 32'(stall), 32'd0);
    next_cycle();
  endtask

  // samples busy/done in the current cycle
  task automatic expect_md(input string tag, input logic busy, input logic done);
    @(negedge clk);
    check({tag, "_busy"}, 32'(hilo_busy), 32'(busy));
    check({tag, "_done"}, 32'(md_done), 32'(done));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'b00; funct = '0; opcode = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    // reset state and idle
    @(negedge clk);
    check("rst_operation", 32'(operation), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(hilo_busy), 32'd0);
    next_cycle();
    idle(3);

    // decode sweep, back to back
    issue(2'b10, 6'h22, 6'h00, 1'b0, A_SUB);
    issue(2'b11, 6'h00, 6'h0F, 1'b0, A_LUI);
    issue(2'b01, 6'h00, 6'h01, 1'b0, A_BGEZ);
    issue(2'b00, 6'h15, 6'h23, 1'b0, A_ADD);
    issue(2'b01, 6'h00, 6'h04, 1'b0, A_BEQ);
    issue(2'b10, 6'h27, 6'h00, 1'b0, A_NOR);
    issue(2'b11, 6'h00, 6'h0C, 1'b0, A_AND);
    issue(2'b11, 6'h00, 6'h0D, 1'b0, A_OR);
    issue(2'b11, 6'h00, 6'h0A, 1'b0, A_SLT);
    issue(2'b10, 6'h22, 6'h00, 1'b0, A_SUB);
    // illegal ones: Operation holds ALU_SUB
    issue(2'b10, 6'h3F, 6'h00, 1'b1, A_SUB);
    issue(2'b01, 6'h00, 6'h05, 1'b1, A_SUB);
    issue(2'b11, 6'h00, 6'h3E, 1'b1, A_SUB);
    idle(1);
    @(negedge clk);
    check("illegal_no_busy", 32'(hilo_busy), 32'd0);
    check("illegal_op_held", 32'(operation), 32'(A_SUB));
    next_cycle();

    // random legal non-HI/LO R-types interleaved with idles
    for (int i = 0; i < 20; i++) begin
      int k;
      logic [5:0] fs [4];
      logic [5:0] os [4];
      fs = '{6'h20, 6'h24, 6'h25, 6'h2A};
      os = '{A_ADD, A_AND, A_OR, A_SLT};
      k = $urandom_range(0, 3);
      issue(2'b10, fs[k], 6'h00, 1'b0, os[k]);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    // MULT timing: busy cycles 1..4, md_done cycle 5
    issue(2'b10, 6'h18, 6'h00, 1'b0, A_MULT);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      expect_md("mult_cyc", 1'b1, 1'b0);
      next_cycle();
    end
    expect_md("mult_end", 1'b0, 1'b1);
    next_cycle();
    expect_md("mult_after", 1'b0, 1'b0);
    next_cycle();

    // DIV timing: busy cycles 1..32, md_done cycle 33
    issue(2'b10, 6'h1A, 6'h00, 1'b0, A_DIV);
    in_valid = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      expect_md("div_cyc", 1'b1, 1'b0);
      next_cycle();
    end
    expect_md("div_end", 1'b0, 1'b1);
    next_cycle();
    idle(2);

    // stall: MULT c0, ADD c1, MFLO held from c2, accepted c5
    issue(2'b10, 6'h18, 6'h00, 1'b0, A_MULT);
    issue(2'b10, 6'h20, 6'h00, 1'b0, A_ADD);
    drive(2'b10, 6'h12, 6'h00);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("mflo_stall", 32'(stall), 32'd1);
      next_cycle();
    end
    exp_q.push_back({1'b0, A_MFLO});
    @(negedge clk);
    check("mflo_accept_stall", 32'(stall), 32'd0);
    check("mflo_accept_done", 32'(md_done), 32'd1);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("mflo_op", 32'(operation), 32'(A_MFLO));
    check("mflo_valid", 32'(out_valid), 32'd1);
    next_cycle();

    // MULT re-armed in the md_done cycle
    issue(2'b10, 6'h18, 6'h00, 1'b0, A_MULT);
    drive(2'b10, 6'h18, 6'h00);
    for (int c = 1; c <= 4; c++) next_cycle();
    exp_q.push_back({1'b0, A_MULT});
    @(negedge clk);
    check("rearm_done", 32'(md_done), 32'd1);
    check("rearm_stall", 32'(stall), 32'd0);
    next_cycle();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      expect_md("rearm_cyc", 1'b1, 1'b0);
      next_cycle();
    end
    expect_md("rearm_end", 1'b0, 1'b1);
    next_cycle();
    idle(2);

    // reset mid-DIV abandons it with no md_done
    issue(2'b10, 6'h1A, 6'h00, 1'b0, A_DIV);
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) next_cycle();
    md_done_seen = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(hilo_busy), 32'd0);
    check("rst_mid_operation", 32'(operation), 32'd0);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(40);
    check("rst_no_md_done", 32'(md_done_seen), 32'd0);
    issue(2'b10, 6'h10, 6'h00, 1'b0, A_MFHI);
    idle(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised ALU control unit: decodes ALUOp/Function/Opcode into the ALU operation code with a valid handshake and fixed one-cycle latency, with no delay statements.
- Tracks multi-cycle MULT/DIV occupancy of HI/LO with a countdown counter.
- Stalls HI/LO-dependent instructions while MULT/DIV is in flight; independent ops issue freely.
- Flags undecodable instructions.
- Sits between the main control unit and the ALU/HI-LO datapath.

Parameters:
- FUNC_SIZE, 6, width of Function field
- OP_SIZE, 6, width of Opcode field and Operation output
- MULT_CYCLES, 4, cycles HI/LO stay busy after MULT issue (>=1)
- DIV_CYCLES, 32, cycles HI/LO stay busy after DIV issue (>=1)
- Encodings F_*, OP_*, ALU_* come from parameters.v: F_ADD 20h, F_SUB 22h, F_AND 24h, F_OR 25h, F_NOR 27h, F_SLT 2Ah, F_SLL 00h, F_SRL 02h, F_MULT 18h, F_DIV 1Ah, F_MFHI 10h, F_MFLO 12h, OP_BGEZ 01h, OP_BEQ 04h, OP_ADDI 08h, OP_SLTI 0Ah, OP_ANDI 0Ch, OP_ORI 0Dh, OP_LUI 0Fh

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction fields valid this cycle
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
- Function  in  FUNC_SIZE  R-type funct field
- Opcode  in  OP_SIZE  instruction opcode
- stall  out  1  combinational; in_valid high but instruction not accepted this cycle
- Operation  out  OP_SIZE  registered ALU operation code
- out_valid  out  1  one-cycle pulse; Operation updated this cycle
- illegal  out  1  qualifies out_valid; instruction was not decodable
- hilo_busy  out  1  MULT/DIV in flight
- md_done  out  1  one-cycle pulse; HI/LO result ready

Behaviour:
- Reset (async assert, sync release): Operation=0, out_valid=0, illegal=0, hilo_busy=0, md_done=0, counter=0. Reset mid-MULT/DIV abandons it with no md_done.
- Decode map:
  - ALUOp 00 -> ALU_ADD.
  - ALUOp 01: OP_BEQ->ALU_BEQ, OP_BGEZ->ALU_BGEZ.
  - ALUOp 10: F_ADD/SUB/AND/NOR/OR/SLT/DIV/MULT/MFHI/MFLO/SLL/SRL -> matching ALU_* code.
  - ALUOp 11: OP_ADDI->ALU_ADD, OP_ORI->ALU_OR, OP_ANDI->ALU_AND, OP_SLTI->ALU_SLT, OP_LUI->ALU_LUI.
  - Any other combination is illegal.
- HI/LO-class ops: R-type F_MULT, F_DIV, F_MFHI, F_MFLO.
- Stall rule: stall = in_valid & hilo_busy & HI/LO-class. Accept = in_valid & ~stall. Inputs are held stable by the producer while stalled.
- On accept at edge N:
  - Edge N+1: out_valid=1 for one cycle.
  - Legal op: Operation = decoded code, illegal=0.
  - Illegal op: Operation holds its previous value, illegal=1. No counter effect.
- Non-accept cycles: out_valid=0, illegal=0, Operation holds.
- Back-to-back accepts produce back-to-back out_valid pulses, giving a throughput of 1/cycle.
- Counter, width clog2(max(MULT_CYCLES,DIV_CYCLES))+1:
  - On accepted MULT (DIV), load MULT_CYCLES-1 (DIV_CYCLES-1) and set hilo_busy.
  - While hilo_busy and counter>0, decrement each cycle.
  - While hilo_busy and counter==0, the next edge clears hilo_busy and pulses md_done.
  - hilo_busy is high for exactly MULT_CYCLES (DIV_CYCLES) cycles, starting the cycle after accept.
  - md_done rises the same cycle hilo_busy falls.
- Simultaneous events:
  - A HI/LO-class instruction presented in the cycle hilo_busy is still 1 is stalled.
  - It is accepted in the first cycle hilo_busy=0, which is the md_done cycle.
  - A new MULT accepted in the md_done cycle re-arms the counter normally.
- Non-HI/LO ops are accepted while hilo_busy=1 and do not disturb the counter.

Test Plan:
- Reset then idle: rst_n=0 mid-run -> all outputs 0 immediately. After release with in_valid=0 -> out_valid stays 0.
- Decode sweep, one per cycle: ALUOp=10/F=22h -> ALU_SUB one cycle later. ALUOp=11/Op=0Fh -> ALU_LUI. ALUOp=01/Op=01h -> ALU_BGEZ. ALUOp=00 -> ALU_ADD. Each gives out_valid=1, illegal=0, no bubbles.
- Illegal: ALUOp=10/F=3Fh after an ALU_SUB -> out_valid=1, illegal=1, Operation stays ALU_SUB, hilo_busy=0.
- MULT timing: MULT accepted at cycle 0 -> hilo_busy=1 in cycles 1..4, md_done=1 in cycle 5. Repeat for DIV: busy cycles 1..32, md_done in cycle 33.
- Stall: MULT at cycle 0, ADD at cycle 1 (accepted, out_valid cycle 2), MFLO held from cycle 2 -> stall=1 in cycles 2..4, accepted cycle 5, Operation=ALU_MFLO in cycle 6.
- Reset mid-DIV: rst_n low at cycle 10 of DIV -> hilo_busy=0 at once. md_done never pulses. A subsequent MFHI is accepted with no stall.
